// File: rtl/div_ratio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_ratio_ctrl
//  Purpose  : Run-time controller for one programmable divide-by-N
//             clock-enable path. Handles start/stop, ratio changes that take
//             effect only at period boundaries, a near-50% duty output and a
//             per-period tick.
//  Ports    : clk        - clock, all logic on rising edge
//             rst        - synchronous reset, active-low
//             run        - 1 = divide, 0 = stop at end of current period
//             cfg_valid  - new divisor request valid
//             cfg_div    - requested divisor N
//             cfg_ready  - request can be accepted (valid & ready = accepted)
//             out        - divided output, registered
//             tick       - 1-cycle pulse in the last cycle of each period
//             count      - position in the current period, 0..N-1
//             busy       - controller is dividing (not idle)
//             err        - 1-cycle pulse: request rejected (N < MIN_DIV)
//  Revision : 1.0 - initial release
// ============================================================================
module div_ratio_ctrl #(
    parameter int CNT_W   = 7,
    parameter int DEF_DIV = 12,
    parameter int MIN_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             out,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_MIN_DIV = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_count;
    logic             r_out;
    logic             r_err;
    logic             r_pend;
    logic [CNT_W-1:0] r_pdiv;

    state_t           w_state_n;
    logic [CNT_W-1:0] w_div_n;
    logic [CNT_W-1:0] w_count_n;
    logic             w_out_n;
    logic             w_err_n;
    logic             w_pend_n;
    logic [CNT_W-1:0] w_pdiv_n;

    logic             w_busy;
    logic             w_last;
    logic             w_wrap;
    logic             w_acc;
    logic             w_bad;
    logic [CNT_W-1:0] w_count_inc;
    logic [CNT_W:0]   w_high;

    assign w_busy      = (r_state != IDLE);
    assign w_last      = (r_count == (r_div - c_ONE));
    assign w_wrap      = w_busy & w_last;
    assign w_acc       = cfg_valid & ~r_pend;
    assign w_bad       = (cfg_div < c_MIN_DIV);
    assign w_count_inc = r_count + c_ONE;
    // High-phase length H = ceil(N/2); one extra bit so N=127 cannot overflow.
    assign w_high      = ({1'b0, r_div} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

    always_comb begin
        w_state_n = r_state;
        w_div_n   = r_div;
        w_count_n = r_count;
        w_out_n   = r_out;
        w_err_n   = w_acc & w_bad;
        w_pend_n  = r_pend;
        w_pdiv_n  = r_pdiv;

        // Divisor update: a held request lands at the wrap; a fresh legal
        // request lands immediately when idle or on the wrap itself, and is
        // parked otherwise so the running period is never disturbed.
        if (w_wrap && r_pend) begin
            w_div_n  = r_pdiv;
            w_pend_n = 1'b0;
        end
        if (w_acc && !w_bad) begin
            if (!w_busy || w_wrap) begin
                w_div_n = cfg_div;
            end else begin
                w_pend_n = 1'b1;
                w_pdiv_n = cfg_div;
            end
        end

        case (r_state)
            IDLE: begin
                w_count_n = '0;
                w_out_n   = 1'b0;
                if (run) begin
                    w_state_n = RUN;
                    w_out_n   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (w_last) begin
                    w_count_n = '0;
                    if (run) begin
                        w_state_n = RUN;
                        // Count 0 always lies in the high phase (H >= 1).
                        w_out_n   = 1'b1;
                    end else begin
                        w_state_n = IDLE;
                        w_out_n   = 1'b0;
                    end
                end else begin
                    w_count_n = w_count_inc;
                    w_out_n   = ({1'b0, w_count_inc} < w_high);
                    w_state_n = run ? RUN : DRAIN;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_count_n = '0;
                w_out_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_div   <= c_DEF_DIV;
            r_count <= '0;
            r_out   <= 1'b0;
            r_err   <= 1'b0;
            r_pend  <= 1'b0;
            r_pdiv  <= c_DEF_DIV;
        end else begin
            r_state <= w_state_n;
            r_div   <= w_div_n;
            r_count <= w_count_n;
            r_out   <= w_out_n;
            r_err   <= w_err_n;
            r_pend  <= w_pend_n;
            r_pdiv  <= w_pdiv_n;
        end
    end

    assign cfg_ready = ~r_pend;
    assign out       = r_out;
    assign tick      = w_wrap;
    assign count     = r_count;
    assign busy      = w_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_div_ratio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_ratio_ctrl
//  Purpose  : Self-checking bench for div_ratio_ctrl. Directed scenarios
//             followed by randomized run/config/reset traffic, all compared
//             every cycle against a period-level reference model.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_ratio_ctrl;

    localparam int CNT_W   = 7;
    localparam int DEF_DIV = 12;
    localparam int MIN_DIV = 2;

    logic             clk;
    logic             rst;
    logic             run;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             out;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             err;

    div_ratio_ctrl #(
        .CNT_W  (CNT_W),
        .DEF_DIV(DEF_DIV),
        .MIN_DIV(MIN_DIV)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .out      (out),
        .tick     (tick),
        .count    (count),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the period as a whole (active flag, position,
    // divisor in force, held request).
    bit m_busy  = 0;
    int m_pos   = 0;
    int m_div   = DEF_DIV;
    bit m_pend  = 0;
    int m_pdiv  = DEF_DIV;
    bit m_err   = 0;
    bit m_acc   = 0;

    task automatic model_edge(input bit r, input bit rn, input bit v, input int d);
        bit acc, bad, wrap;
        int nd;
        if (!r) begin
            m_busy = 0; m_pos = 0; m_div = DEF_DIV; m_pend = 0; m_err = 0; m_acc = 0;
            return;
        end
        acc  = v && !m_pend;
        bad  = d < MIN_DIV;
        wrap = m_busy && (m_pos == m_div - 1);
        m_acc = acc;
        m_err = acc && bad;
        nd = m_div;
        if (wrap && m_pend) begin nd = m_pdiv; m_pend = 0; end
        if (acc && !bad) begin
            if (!m_busy || wrap) nd = d;
            else begin m_pend = 1; m_pdiv = d; end
        end
        if (m_busy) begin
            if (wrap) begin m_pos = 0; m_busy = rn; end
            else m_pos = m_pos + 1;
        end else if (rn) begin
            m_busy = 1; m_pos = 0;
        end
        m_div = nd;
    endtask

    task automatic check_all();
        logic [CNT_W-1:0] e_count;
        logic             e_out, e_tick, e_busy, e_rdy, e_err;
        e_count = CNT_W'(m_pos);
        e_busy  = m_busy;
        e_out   = m_busy && (m_pos < (m_div + 1) / 2);
        e_tick  = m_busy && (m_pos == m_div - 1);
        e_rdy   = !m_pend;
        e_err   = m_err;
        checks++;
        assert (count === e_count) else begin
            errors++; $error("FAIL count observed=%0d expected=%0d", count, e_count);
        end
        checks++;
        assert (out === e_out) else begin
            errors++; $error("FAIL out observed=%b expected=%b (pos=%0d div=%0d)", out, e_out, m_pos, m_div);
        end
        checks++;
        assert (tick === e_tick) else begin
            errors++; $error("FAIL tick observed=%b expected=%b", tick, e_tick);
        end
        checks++;
        assert (busy === e_busy) else begin
            errors++; $error("FAIL busy observed=%b expected=%b", busy, e_busy);
        end
        checks++;
        assert (cfg_ready === e_rdy) else begin
            errors++; $error("FAIL cfg_ready observed=%b expected=%b", cfg_ready, e_rdy);
        end
        checks++;
        assert (err === e_err) else begin
            errors++; $error("FAIL err observed=%b expected=%b", err, e_err);
        end
    endtask

    // One clock: apply inputs, advance model with the same inputs, check.
    task automatic cyc(input bit r, input bit rn, input bit v, input int d);
        rst = r; run = rn; cfg_valid = v; cfg_div = CNT_W'(d);
        @(posedge clk);
        model_edge(r, rn, v, d);
        #1;
        check_all();
    endtask

    bit cur_run = 0;

    // Idle-config cycles until the model reaches position p (bounded).
    task automatic run_to(input int p);
        for (int i = 0; i < 300; i++) begin
            if (m_busy && m_pos == p) return;
            cyc(1, cur_run, 0, 0);
        end
        checks++; errors++;
        $error("FAIL run_to position=%0d not reached", p);
    endtask

    initial begin
        int  highs;
        bit  hold_v;
        int  hold_d;
        rst = 0; run = 0; cfg_valid = 0; cfg_div = '0;

        // T1: reset, then free-running N=12.
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cur_run = 1;
        for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0);

        // T2: request 9 at count 3 -> held until the wrap.
        run_to(3);
        cyc(1, 1, 1, 9);
        for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0);

        // T4: illegal divisors rejected.
        cyc(1, 1, 1, 1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);

        // Back to 12, then T5: stop at count 5, drain to idle.
        run_to(2);
        cyc(1, 1, 1, 12);
        run_to(0);
        run_to(5);
        cur_run = 0;
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
        cur_run = 1;
        cyc(1, 1, 0, 0);
        run_to(5);
        cur_run = 0;
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cur_run = 1;
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);
        cur_run = 0;
        for (int i = 0; i < 14; i++) cyc(1, 0, 0, 0);

        // T3: configure 80 while idle, run one period, count high cycles.
        cyc(1, 0, 1, 80);
        cur_run = 1;
        highs = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(1, 1, 0, 0);
            if (out === 1'b1) highs++;
        end
        checks++;
        assert (highs == 40) else begin
            errors++; $error("FAIL high_cycles_n80 observed=%0d expected=40", highs);
        end

        // T6: restore 12, pend 9, reset mid-period.
        run_to(10);
        cyc(1, 1, 1, 12);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        run_to(1);
        cyc(1, 1, 1, 9);
        run_to(4);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 26; i++) cyc(1, 1, 0, 0);

        // Randomized traffic.
        hold_v = 0; hold_d = 0;
        for (int i = 0; i < 4000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 29) == 0) cur_run = !cur_run;
            if (!hold_v && $urandom_range(0, 11) == 0) begin
                hold_v = 1;
                case ($urandom_range(0, 7))
                    0:       hold_d = $urandom_range(0, 1);
                    1:       hold_d = $urandom_range(2, 127);
                    default: hold_d = $urandom_range(2, 16);
                endcase
            end
            cyc(r, cur_run, hold_v, hold_d);
            if (m_acc || !r) hold_v = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
